ram_nn_seq: RTL
===============

Name: ram_nn_seq

Overview:
- Time-multiplexed successor to the per-layer RAM network chain. One shared signed MAC engine evaluates up to MaxLayers fully-connected layers in sequence.
- Layer count, per-layer widths and per-layer activation mode are runtime-configurable.
- Activations live in internal ping-pong buffers. Weights and biases stream from an external synchronous weight RAM.
- Sits between the input-activation loader and the classifier readout, using the same req/ack handshake as the layer chain.

Parameters:
- DataWidth, 8, signed activation/weight width
- FpWidth, 4, fractional bits (1.0 = 1<<FpWidth)
- MaxWidth, 64, max neurons/inputs per layer
- MaxLayers, 4, max layers evaluated
- WgtAddrWidth, 16, weight RAM address width
- AddrWidth, $clog2(MaxWidth), activation buffer address width
- SizeWidth, $clog2(MaxWidth+1), width of one size field
- AccWidth, 2*DataWidth+$clog2(MaxWidth+1)+1, accumulator width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- req_i  in  1  start request (4-phase)
- ack_o  out  1  done; held until req_i low
- busy_o  out  1  high from accept until ack_o rises
- err_o  out  1  config error flag, valid while ack_o high
- num_layers_i  in  $clog2(MaxLayers+1)  layers to run
- layer_size_i  in  (MaxLayers+1)*SizeWidth  field 0 = input count; field L = neurons of layer L
- act_mode_i  in  2*MaxLayers  per layer: 0 linear, 1 ReLU, 2 leaky (x>>>3 if negative), 3 linear
- actv_in_we  in  1  input buffer write enable
- actv_in_addr  in  AddrWidth  input buffer write address
- actv_in_din  in  DataWidth  input activation
- actv_out_addr  in  AddrWidth  result read address
- actv_out_dout  out  DataWidth  result, combinational read of the final buffer
- wgt_ram_addr_o  out  WgtAddrWidth  weight RAM address
- wgt_ram_re_o  out  1  weight RAM read enable
- wgt_ram_data_i  in  DataWidth  weight RAM data, 1-cycle read latency

Behaviour:
- Reset (async, reset_i=0):
  - ack_o, busy_o, err_o, wgt_ram_re_o and wgt_ram_addr_o = 0.
  - Both buffers cleared to 0; FSM returns to IDLE; final-buffer select = A.
  - Mid-run reset aborts the run with no partial ack.
- Buffers: A and B, each MaxWidth x DataWidth.
  - actv_in_we writes A only in IDLE; writes are ignored otherwise.
  - Layer L reads A and writes B when L is odd; it reads B and writes A when L is even.
  - actv_out_dout reads the buffer written last. After a config error it reads A.
- FSM states: IDLE -> CHECK -> FETCH/MAC -> BIAS -> WRITE -> (next neuron | next layer | DONE) -> WAIT_REL -> IDLE.
  - IDLE: req_i=1 latches num_layers_i, layer_size_i and act_mode_i, raises busy_o, and moves to CHECK.
  - CHECK (1 cycle): error if num_layers=0 or >MaxLayers, or any used size field is 0 or >MaxWidth. On error go to DONE with err_o=1 and no weight reads.
  - FETCH/MAC: per neuron, issue n_in weight addresses then the bias address on consecutive cycles, with wgt_ram_re_o=1. Data returns one cycle later. Each weight is multiplied by activation[k] and accumulated as a full-precision signed product.
  - BIAS: acc += sign-extended bias << FpWidth.
  - WRITE: result = acc >>> FpWidth, saturated to [-2^(DataWidth-1), 2^(DataWidth-1)-1], then the activation is applied. The result is written to the output buffer at the neuron index.
  - Cost: each neuron takes exactly n_in+3 cycles.
  - DONE: ack_o=1, busy_o=0. WAIT_REL holds ack_o until req_i=0; ack_o drops the following cycle.
- Latency: ack_o rises 1 + sum over L of n_L*(n_{L-1}+3) cycles after the accepting edge. A config error gives 1 cycle.
- Weight layout: contiguous from address 0. Layer by layer, neuron by neuron: n_in weights then 1 bias. wgt_ram_addr_o increments by 1 per issued read and never wraps inside a valid config.
- req_i dropping mid-run is ignored. Config inputs changing mid-run are ignored because they were latched at accept.
- wgt_ram_re_o=0 outside FETCH.

Test Plan:
1. 1 layer, sizes {2,1}, mode 0; A = {16,32}; weights {16,16}, bias 16 -> out[0]=64; ack_o at cycle 6; err_o=0.
2. Saturation and activation modes:
   - Inputs {127,127}, weights {127,127}, bias 0 -> 127.
   - Inputs {16}, weight -64, bias 0, mode 1 -> 0.
   - Same stimulus, mode 2 -> -8.
3. 2 layers, sizes {2,2,1}, all-16 weights and biases, inputs {16,16} -> layer1 = {48,48} in B; layer2 = 112, read from A; latency 1+2*5+1*5 = 16.
4. Config errors:
   - num_layers=0 -> ack_o after 1 cycle, err_o=1, no wgt_ram_re_o.
   - Size field 65 (MaxWidth 64) -> same response.
5. Handshake:
   - Hold req_i high 10 cycles after ack -> ack_o stays 1; drop req -> ack_o=0 next cycle.
   - actv_in_we while busy -> buffer unchanged.
6. Assert reset_i=0 mid-MAC -> outputs 0 immediately; buffers read 0; a new run completes correctly.

Source files
------------

// File: rtl/ram_nn_seq.sv
// Time-multiplexed fully-connected network: one signed MAC walks every neuron of
// every layer, ping-ponging activations between buffers A and B.
module ram_nn_seq #(
  parameter int DataWidth    = 8,
  parameter int FpWidth      = 4,
  parameter int MaxWidth     = 64,
  parameter int MaxLayers    = 4,
  parameter int WgtAddrWidth = 16,
  parameter int AddrWidth    = $clog2(MaxWidth),
  parameter int SizeWidth    = $clog2(MaxWidth+1),
  parameter int AccWidth     = 2*DataWidth + $clog2(MaxWidth+1) + 1,
  parameter int NlWidth      = $clog2(MaxLayers+1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               req_i,
  output logic                               ack_o,
  output logic                               busy_o,
  output logic                               err_o,
  input  logic [NlWidth-1:0]                 num_layers_i,
  input  logic [(MaxLayers+1)*SizeWidth-1:0] layer_size_i,
  input  logic [2*MaxLayers-1:0]             act_mode_i,
  input  logic                               actv_in_we,
  input  logic [AddrWidth-1:0]               actv_in_addr,
  input  logic [DataWidth-1:0]               actv_in_din,
  input  logic [AddrWidth-1:0]               actv_out_addr,
  output logic [DataWidth-1:0]               actv_out_dout,
  output logic [WgtAddrWidth-1:0]            wgt_ram_addr_o,
  output logic                               wgt_ram_re_o,
  input  logic [DataWidth-1:0]               wgt_ram_data_i
);

  // 4-phase req/ack: req_i high in IDLE starts a run; ack_o rises when done and holds
  // until req_i is seen low, dropping on the next edge. req_i is ignored mid-run.
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_BIAS, S_WRITE, S_DONE, S_WAIT_REL
  } state_t;

  state_t                      r_state, w_next;
  logic [NlWidth-1:0]          r_nl, r_layer;
  logic [SizeWidth-1:0]        r_size [MaxLayers+1];
  logic [1:0]                  r_mode [MaxLayers+1];
  logic [AddrWidth-1:0]        r_neuron;
  logic [SizeWidth-1:0]        r_k;
  logic signed [AccWidth-1:0]  r_acc;
  logic [WgtAddrWidth-1:0]     r_addr;
  logic                        r_err, r_sel_b;
  logic [DataWidth-1:0]        r_buf_a [MaxWidth];
  logic [DataWidth-1:0]        r_buf_b [MaxWidth];

  logic                          w_cfg_err, w_last_neuron, w_last_layer, w_fetch_last;
  logic [SizeWidth-1:0]          w_n_in, w_n_out;
  logic [AddrWidth-1:0]          w_kidx;
  logic [DataWidth-1:0]          w_act, w_result;
  logic signed [2*DataWidth-1:0] w_prod;
  logic signed [AccWidth-1:0]    w_prod_ext, w_bias_ext, w_shift;
  logic                          w_in_range;
  logic signed [DataWidth-1:0]   w_sat;

  assign w_n_in        = r_size[r_layer - 1'b1];
  assign w_n_out       = r_size[r_layer];
  assign w_last_neuron = (SizeWidth'(r_neuron) + 1'b1) == w_n_out;
  assign w_last_layer  = (r_layer == r_nl);
  assign w_fetch_last  = (r_k == w_n_in);

  always_comb begin
    w_cfg_err = (r_nl == '0) || (r_nl > NlWidth'(MaxLayers));
    for (int i = 0; i <= MaxLayers; i++) begin
      if ((i <= int'(r_nl)) && ((r_size[i] == '0) || (r_size[i] > SizeWidth'(MaxWidth))))
        w_cfg_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (req_i) w_next = S_CHECK;
      S_CHECK:    w_next = w_cfg_err ? S_DONE : S_FETCH;
      S_FETCH:    if (w_fetch_last) w_next = S_BIAS;
      S_BIAS:     w_next = S_WRITE;
      S_WRITE:    w_next = (w_last_neuron && w_last_layer) ? S_DONE : S_FETCH;
      S_DONE:     w_next = S_WAIT_REL;
      S_WAIT_REL: if (!req_i) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (r_state == S_CHECK) || (r_state == S_FETCH) ||
                   (r_state == S_BIAS)  || (r_state == S_WRITE);
    ack_o        = (r_state == S_DONE) || (r_state == S_WAIT_REL);
    wgt_ram_re_o = (r_state == S_FETCH);
  end

  assign err_o          = r_err;
  assign wgt_ram_addr_o = r_addr;

  // Odd layers read A; the weight for index k-1 returns while address k is issued.
  assign w_kidx     = r_k[AddrWidth-1:0] - 1'b1;
  assign w_act      = r_layer[0] ? r_buf_a[w_kidx] : r_buf_b[w_kidx];
  assign w_prod     = $signed(wgt_ram_data_i) * $signed(w_act);
  assign w_prod_ext = {{(AccWidth-2*DataWidth){w_prod[2*DataWidth-1]}}, w_prod};
  assign w_bias_ext = {{(AccWidth-DataWidth-FpWidth){wgt_ram_data_i[DataWidth-1]}},
                       wgt_ram_data_i, {FpWidth{1'b0}}};

  assign w_shift    = r_acc >>> FpWidth;
  assign w_in_range = (&w_shift[AccWidth-1:DataWidth-1]) | ~(|w_shift[AccWidth-1:DataWidth-1]);
  assign w_sat      = w_in_range ? w_shift[DataWidth-1:0] :
                      (w_shift[AccWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}}
                                           : {1'b0, {(DataWidth-1){1'b1}}});

  always_comb begin
    w_result = w_sat;
    case (r_mode[r_layer])
      2'd1:    if (w_sat[DataWidth-1]) w_result = '0;
      2'd2:    if (w_sat[DataWidth-1]) w_result = w_sat >>> 3;
      default: w_result = w_sat;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_nl     <= '0;
      r_layer  <= '0;
      r_neuron <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_addr   <= '0;
      r_err    <= 1'b0;
      r_sel_b  <= 1'b0;
      for (int i = 0; i <= MaxLayers; i++) begin
        r_size[i] <= '0;
        r_mode[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (req_i) begin
          r_nl <= num_layers_i;
          for (int i = 0; i <= MaxLayers; i++)
            r_size[i] <= layer_size_i[i*SizeWidth +: SizeWidth];
          r_mode[0] <= '0;
          for (int i = 1; i <= MaxLayers; i++)
            r_mode[i] <= act_mode_i[(i-1)*2 +: 2];
          r_layer  <= NlWidth'(1);
          r_neuron <= '0;
          r_k      <= '0;
          r_addr   <= '0;
          r_err    <= 1'b0;
        end
        S_CHECK: if (w_cfg_err) begin
          r_err   <= 1'b1;
          r_sel_b <= 1'b0;
        end
        S_FETCH: begin
          r_addr <= r_addr + 1'b1;
          r_k    <= r_k + 1'b1;
          r_acc  <= (r_k == '0) ? '0 : r_acc + w_prod_ext;
        end
        S_BIAS: r_acc <= r_acc + w_bias_ext;
        S_WRITE: begin
          r_k     <= '0;
          r_sel_b <= r_layer[0];
          if (w_last_neuron) begin
            r_neuron <= '0;
            r_layer  <= r_layer + 1'b1;
          end else begin
            r_neuron <= r_neuron + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < MaxWidth; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else begin
      if ((r_state == S_IDLE) && actv_in_we) r_buf_a[actv_in_addr] <= actv_in_din;
      if (r_state == S_WRITE) begin
        if (r_layer[0]) r_buf_b[r_neuron] <= w_result;
        else            r_buf_a[r_neuron] <= w_result;
      end
    end
  end

  assign actv_out_dout = r_sel_b ? r_buf_b[actv_out_addr] : r_buf_a[actv_out_addr];

endmodule
